// File: rtl/ibex_shadow_stack_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ibex_shadow_stack_ctrl_if : retire-side and shadow-stack-side signal bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ibex_shadow_stack_ctrl_if;
  logic        enable_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        is_compressed_i;
  logic [31:0] pc_i;
  logic [31:0] jump_target_i;
  logic        stall_o;
  logic        push_o;
  logic [31:0] push_addr_o;
  logic        pop_o;
  logic [31:0] pop_addr_o;
  logic        stack_error_i;
  logic        clear_alert_i;
  logic        alert_o;

  // Core / shadow-stack side
  modport master (
    output enable_i, instr_valid_i, instr_i, is_compressed_i, pc_i, jump_target_i,
    output stack_error_i, clear_alert_i,
    input  stall_o, push_o, push_addr_o, pop_o, pop_addr_o, alert_o
  );

  // Controller side
  modport slave (
    input  enable_i, instr_valid_i, instr_i, is_compressed_i, pc_i, jump_target_i,
    input  stack_error_i, clear_alert_i,
    output stall_o, push_o, push_addr_o, pop_o, pop_addr_o, alert_o
  );
endinterface
`default_nettype wire

// File: rtl/ibex_shadow_stack_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ibex_shadow_stack_ctrl : call/return classifier and shadow-stack event issuer
// Revision: 1.0
// ----------------------------------------------------------------------------
module ibex_shadow_stack_ctrl #(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  ibex_shadow_stack_ctrl_if.slave  bus
);
  localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    STALL_TH  = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic           TYPE_PUSH = 1'b1;
  localparam logic           TYPE_POP  = 1'b0;

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e      state, state_next;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count, wptr_p1;
  logic        empty, stall, accept, err_event, issue;
  logic [1:0]  enq_n, store_n;
  logic [32:0] e0, e1, s0, s1, head;
  logic [31:0] ret_addr;
  logic        rd_link, rs1_link;
  logic        push_q, pop_q, alert_q;
  logic [31:0] push_addr_q, pop_addr_q;
  logic        unused_bits;

  assign unused_bits = ^{bus.instr_i[31:20], RV32E};

  assign count     = wptr - rptr;
  assign wptr_p1   = wptr + (AW+1)'(1);
  assign empty     = (count == '0);
  assign stall     = (state == HALT) || (count > STALL_TH);
  assign accept    = bus.instr_valid_i && bus.enable_i && !stall;
  assign err_event = bus.stack_error_i && (push_q || pop_q);
  assign ret_addr  = bus.pc_i + (bus.is_compressed_i ? 32'd2 : 32'd4);
  assign rd_link   = (bus.instr_i[11:7] == 5'd1) || (bus.instr_i[11:7] == 5'd5);
  assign rs1_link  = (bus.instr_i[19:15] == 5'd1) || (bus.instr_i[19:15] == 5'd5);

  always_comb begin
    enq_n = 2'd0;
    e0    = '0;
    e1    = '0;
    if (accept) begin
      if (bus.instr_i[6:0] == 7'b1101111) begin
        if (rd_link) begin
          enq_n = 2'd1;
          e0    = {TYPE_PUSH, ret_addr};
        end
      end else if (bus.instr_i[6:0] == 7'b1100111 && bus.instr_i[14:12] == 3'b000) begin
        if (rd_link && rs1_link && (bus.instr_i[11:7] != bus.instr_i[19:15])) begin
          // Coroutine swap: validate the old return first, then record the new one
          enq_n = 2'd2;
          e0    = {TYPE_POP, bus.jump_target_i};
          e1    = {TYPE_PUSH, ret_addr};
        end else if (rd_link) begin
          enq_n = 2'd1;
          e0    = {TYPE_PUSH, ret_addr};
        end else if (rs1_link) begin
          enq_n = 2'd1;
          e0    = {TYPE_POP, bus.jump_target_i};
        end
      end
    end
  end

  // An empty FIFO forwards the first new entry straight to the outputs
  assign issue = (state == RUN) && !err_event && (!empty || enq_n != 2'd0);
  assign head  = empty ? e0 : mem[rptr[AW-1:0]];

  always_comb begin
    store_n = enq_n;
    s0      = e0;
    s1      = e1;
    if (empty && enq_n != 2'd0) begin
      store_n = enq_n - 2'd1;
      s0      = e1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!err_event) begin
      if (store_n != 2'd0) mem[wptr[AW-1:0]]    <= s0;
      if (store_n == 2'd2) mem[wptr_p1[AW-1:0]] <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (err_event) state_next = HALT;
      HALT:    if (bus.clear_alert_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr        <= '0;
      rptr        <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_addr_q <= '0;
      pop_addr_q  <= '0;
      alert_q     <= 1'b0;
    end else if (err_event) begin
      wptr    <= '0;
      rptr    <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      alert_q <= 1'b1;
    end else begin
      if (bus.clear_alert_i) alert_q <= 1'b0;
      wptr   <= wptr + (AW+1)'(store_n);
      rptr   <= rptr + (AW+1)'(issue && !empty);
      push_q <= issue && (head[32] == TYPE_PUSH);
      pop_q  <= issue && (head[32] == TYPE_POP);
      if (issue && head[32] == TYPE_PUSH) push_addr_q <= head[31:0];
      if (issue && head[32] == TYPE_POP)  pop_addr_q  <= head[31:0];
    end
  end

  assign bus.stall_o     = stall;
  assign bus.push_o      = push_q;
  assign bus.pop_o       = pop_q;
  assign bus.push_addr_o = push_addr_q;
  assign bus.pop_addr_o  = pop_addr_q;
  assign bus.alert_o     = alert_q;
endmodule
`default_nettype wire
